// File: rtl/input_mem_read_sequencer.sv
// input_mem_read_sequencer: issues burst reads to the input RAM and streams returned words through a credit-protected FIFO
// Define SEQ_PERF_COUNT_EN to add the stall_cycles performance counter output.
module input_mem_read_sequencer #(
  parameter int ADD_SIZE   = 12,
  parameter int DATA_SIZE  = 108,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_SIZE   = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADD_SIZE-1:0]  base_address,
  input  logic [CNT_SIZE-1:0]  word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 read_en,
  output logic [ADD_SIZE-1:0]  read_address,
  input  logic [DATA_SIZE-1:0] mem_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADD_SIZE-1:0] base;
  logic [CNT_SIZE-1:0] count, issued, accepted;
  logic [CW-1:0] credits, occ;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic full, push, pop;
  assign full         = occ == CW'(FIFO_DEPTH);
  assign m_valid      = occ != '0;
  assign m_data       = m_valid ? mem[rd_ptr] : '0;
  assign mem_ready    = !full;
  assign pop          = m_valid && m_ready;
  // late returns from a burst killed by reset arrive while idle and are discarded
  assign push         = mem_valid && (!full || pop) && state != IDLE;
  assign read_address = base + issued[ADD_SIZE-1:0];
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  always_comb begin
    read_en   = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (word_count == '0) ? DONE : ISSUE;
      ISSUE: begin
        read_en = credits != '0;
        if (read_en && issued + CNT_SIZE'(1) == count) state_nxt = DRAIN;
      end
      DRAIN: if (accepted + CNT_SIZE'(pop) == count) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      base     <= '0;
      count    <= '0;
      issued   <= '0;
      accepted <= '0;
      credits  <= CW'(FIFO_DEPTH);
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base     <= base_address;
        count    <= word_count;
        issued   <= '0;
        accepted <= '0;
      end else begin
        issued   <= issued + CNT_SIZE'(read_en);
        accepted <= accepted + CNT_SIZE'(pop);
      end
      credits <= credits - CW'(read_en) + CW'(pop);
      occ     <= occ + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= mem_data;
`ifdef SEQ_PERF_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles <= '0;
    else if (state == IDLE && start) stall_cycles <= '0;
    else if (((state == ISSUE && credits == '0) || (m_valid && !m_ready)) && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (rst) assert (!(mem_valid && full && !pop && state != IDLE))
      else $error("input_mem_read_sequencer: mem_valid while return buffer full, word dropped");
`endif
endmodule

// File: tb/tb_input_mem_read_sequencer.sv
// tb_input_mem_read_sequencer: scoreboard bench with a latency-2 RAM model in front of the sequencer
module tb_input_mem_read_sequencer;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, m_ready = 1'b1;
  logic [11:0] base_address = '0;
  logic [12:0] word_count = '0;
  logic busy, done, read_en, mem_valid, mem_ready, m_valid;
  logic [11:0] read_address;
  logic [107:0] mem_data, m_data;
`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] stall_cycles;
`endif
  input_mem_read_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_address(base_address), .word_count(word_count),
    .busy(busy), .done(done), .read_en(read_en), .read_address(read_address),
    .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef SEQ_PERF_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [107:0] mk(input logic [11:0] a);
    return {9{a ^ 12'h5A3}};
  endfunction
  logic v1 = 1'b0, v2 = 1'b0;
  logic [11:0] a1 = '0;
  logic [107:0] d2 = '0;
  always @(posedge clk) begin
    v1 <= read_en;
    a1 <= read_address;
    v2 <= v1;
    d2 <= mk(a1);
  end
  assign mem_valid = v2;
  assign mem_data  = d2;
  logic [107:0] exp_q[$];
  logic [11:0] addr_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, rd_cnt = 0, done_cnt = 0, issued_m = 0, acc_m = 0, burst_cnt = 0, stall_m = 0;
  int first_rd = -1, last_rd = -1;
  logic prev_hold = 1'b0, exp_rd;
  logic [107:0] prev_data = '0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_rd = busy && issued_m < burst_cnt && issued_m - acc_m < 4;
      check("read_en_credit", read_en, exp_rd);
      if ((busy && issued_m < burst_cnt && issued_m - acc_m == 4) || (m_valid && !m_ready)) stall_m++;
      if (prev_hold) check("m_data_hold", m_data, prev_data);
      if (read_en) begin
        rd_cnt++;
        issued_m++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got addr %h expected no read", read_address);
        end else check("read_address", read_address, addr_q.pop_front());
      end
      if (m_valid && m_ready) begin
        acc_m++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no word", m_data);
        end else check("m_data", m_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end else prev_hold = 1'b0;
  end
  task automatic go(input logic [11:0] b, input logic [12:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [11:0] a;
      a = b + 12'(i);
      addr_q.push_back(a);
      exp_q.push_back(mk(a));
    end
    issued_m = 0;
    acc_m = 0;
    burst_cnt = int'(n);
    stall_m = 0;
    rd_cnt = 0;
    first_rd = -1;
    base_address = b;
    word_count = n;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int budget, input bit toggle);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(posedge clk);
      #1;
      if (toggle) m_ready = ~m_ready;
    end
    check("done_pulse", done_cnt - d0, 1);
    check("busy_after_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_done", done_cnt - d0, 1);
    check("words_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
  endtask
  task automatic check_reset_outputs();
    check("rst_read_en", read_en, 1'b0);
    check("rst_read_address", read_address, 12'h000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 108'h0);
    check("rst_mem_ready", mem_ready, 1'b1);
`ifdef SEQ_PERF_COUNT_EN
    check("rst_stall_cycles", stall_cycles, 16'h0);
`endif
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    go(12'h010, 13'd8);
    wait_done(100, 1'b0);
    check("basic_reads", rd_cnt, 8);
    check("basic_consecutive", last_rd - first_rd, 7);
    go(12'hFFE, 13'd4);
    wait_done(100, 1'b0);
    check("wrap_reads", rd_cnt, 4);
    m_ready = 1'b0;
    go(12'h200, 13'd16);
    repeat (20) @(posedge clk);
    #1;
    check("bp_reads", rd_cnt, 4);
    check("bp_mem_ready_full", mem_ready, 1'b0);
    check("bp_m_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    wait_done(200, 1'b0);
    check("bp_total_reads", rd_cnt, 16);
    go(12'h055, 13'd0);
    check("zero_done", done, 1'b1);
    @(posedge clk);
    #1;
    check("zero_done_once", done, 1'b0);
    check("zero_busy_low", busy, 1'b0);
    check("zero_no_reads", rd_cnt, 0);
    go(12'h300, 13'd32);
    for (int i = 0; i < 200 && acc_m < 5; i++) @(posedge clk);
    check("words_before_reset", acc_m, 5);
    #1 rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    burst_cnt = 0;
    issued_m = 0;
    acc_m = 0;
    #1 check_reset_outputs();
    repeat (4) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    go(12'h100, 13'd2);
    wait_done(100, 1'b0);
    check("post_reset_words", acc_m, 2);
    m_ready = 1'b1;
    go(12'h000, 13'd4096);
    wait_done(20000, 1'b1);
    check("full_reads", rd_cnt, 4096);
    check("full_words", acc_m, 4096);
`ifdef SEQ_PERF_COUNT_EN
    check("stall_cycles", stall_cycles, 16'(stall_m));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
